// File: rtl/raster_pkg.sv
// Raster geometry shared by the coordinate distributor and the pixel collector.
package raster_pkg;

  localparam int RASTER_PIXEL_DATA_WIDTH = 10;
  localparam int RASTER_SCREEN_WIDTH     = 640;
  localparam int RASTER_SCREEN_HEIGHT    = 480;

  typedef struct packed {
    logic [RASTER_PIXEL_DATA_WIDTH-1:0] y;
    logic [RASTER_PIXEL_DATA_WIDTH-1:0] x;
  } coord_t;

  // Compared in 32 bits so a dimension equal to 2**width still decodes correctly.
  function automatic logic is_last(input int unsigned v, input int unsigned n);
    return v == n - 1;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster x/y position counter: advances on i_en, wraps at the screen edges,
// decodes start-of-frame and end-of-line.
module raster_counter
  import raster_pkg::*;
#(
  parameter int W             = RASTER_PIXEL_DATA_WIDTH,
  parameter int SCREEN_WIDTH  = RASTER_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = RASTER_SCREEN_HEIGHT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_sof,
  output logic o_eol
);

  if (SCREEN_WIDTH > 2**W || SCREEN_HEIGHT > 2**W) begin : g_dim_check
    $error("raster_counter: screen dimensions do not fit the counter width");
  end

  logic [W-1:0] r_x;
  logic [W-1:0] r_y;
  logic         w_x_last;
  logic         w_y_last;

  assign w_x_last = is_last(32'(r_x), SCREEN_WIDTH);
  assign w_y_last = is_last(32'(r_y), SCREEN_HEIGHT);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_en) begin
      if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_sof = (r_x == '0) && (r_y == '0);
  assign o_eol = w_x_last;

endmodule

// File: rtl/pixel_collector.sv
// Collects one result per engine for each raster batch and streams them in order.
// Define PIXEL_COLLECTOR_DOUBLE_BUFFER_EN for two batch banks (capture while draining).
module pixel_collector
  import raster_pkg::*;
#(
  parameter int PIXEL_DATA_WIDTH = RASTER_PIXEL_DATA_WIDTH,
  parameter int DATA_WIDTH       = 8,
  parameter int SCREEN_WIDTH     = RASTER_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT    = RASTER_SCREEN_HEIGHT,
  parameter int NUM_ENGINES      = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_ENGINES-1:0] done,
  input  logic [DATA_WIDTH-1:0]  result [NUM_ENGINES],
  output logic                   fin_flag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_sof,
  output logic                   out_eol
);

  localparam int LANE_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LANE_W-1:0]     r_lane;
  logic [LANE_W-1:0]     w_lane_nxt;
  logic                  r_fin;
  logic                  w_capture;
  logic                  w_beat;
  logic                  w_last;
  logic                  w_can_capture;
  logic                  w_any_full_nxt;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_sof;
  logic                  w_eol;

  // fin_flag masks done so engines releasing done cannot trigger a second capture.
  assign w_beat    = (r_state == DRAIN) && out_ready;
  assign w_last    = w_beat && (r_lane == LANE_W'(NUM_ENGINES - 1));
  assign w_capture = (&done) && !r_fin && w_can_capture;

`ifdef PIXEL_COLLECTOR_DOUBLE_BUFFER_EN
  logic [DATA_WIDTH-1:0] r_buf [2][NUM_ENGINES];
  logic [1:0]            r_full;
  logic [1:0]            w_full_nxt;
  logic                  r_wr_bank;
  logic                  r_rd_bank;

  assign w_can_capture = !r_full[r_wr_bank];
  assign w_rd_data     = r_buf[r_rd_bank][r_lane];

  always_comb begin
    w_full_nxt = r_full;
    if (w_last)    w_full_nxt[r_rd_bank] = 1'b0;
    if (w_capture) w_full_nxt[r_wr_bank] = 1'b1;
  end

  assign w_any_full_nxt = |w_full_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (w_capture) r_wr_bank <= ~r_wr_bank;
      if (w_last)    r_rd_bank <= ~r_rd_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int i = 0; i < NUM_ENGINES; i++) r_buf[r_wr_bank][i] <= result[i];
    end
  end
`else
  logic [DATA_WIDTH-1:0] r_buf [NUM_ENGINES];

  assign w_can_capture  = (r_state == COLLECT);
  assign w_rd_data      = r_buf[r_lane];
  assign w_any_full_nxt = w_capture || ((r_state == DRAIN) && !w_last);

  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int i = 0; i < NUM_ENGINES; i++) r_buf[i] <= result[i];
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_lane_nxt  = r_lane;
    case (r_state)
      COLLECT: begin
        if (w_capture) begin
          w_state_nxt = DRAIN;
          w_lane_nxt  = '0;
        end
      end
      DRAIN: begin
        if (w_beat) w_lane_nxt = w_last ? '0 : r_lane + 1'b1;
        if (!w_any_full_nxt) w_state_nxt = COLLECT;
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= COLLECT;
      r_lane  <= '0;
      r_fin   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lane  <= w_lane_nxt;
      r_fin   <= w_capture;
    end
  end

  raster_counter #(
    .W             (PIXEL_DATA_WIDTH),
    .SCREEN_WIDTH  (SCREEN_WIDTH),
    .SCREEN_HEIGHT (SCREEN_HEIGHT)
  ) u_raster (
    .i_clk (clk),
    .i_rst (reset),
    .i_en  (w_beat),
    .o_sof (w_sof),
    .o_eol (w_eol)
  );

  // Data is gated by valid so stale buffer contents never appear after reset.
  assign fin_flag  = r_fin;
  assign out_valid = (r_state == DRAIN);
  assign out_data  = out_valid ? w_rd_data : '0;
  assign out_sof   = out_valid && w_sof;
  assign out_eol   = out_valid && w_eol;

endmodule
